// File: rtl/quadrature_debounce.sv
// Rotary encoder front end: synchronise, debounce, step/dir/err strobes.
// Optional saturating illegal-transition counter under QUAD_ERR_COUNT_EN.
module quadrature_debounce #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int CNT_W           = 13
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       quadA,
  input  logic       quadB,
  output logic       quadA_clean,
  output logic       quadB_clean,
  output logic       step,
  output logic       dir,
  output logic       err,
  output logic [7:0] err_count
);

  typedef enum logic {
    S_FILL,
    S_RUN
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_a_s1;
  logic             r_a_s2;
  logic             r_b_s1;
  logic             r_b_s2;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_fill;
  logic             w_fill_nxt;

  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;
  logic [CNT_W-1:0] w_cnt_a_nxt;
  logic [CNT_W-1:0] w_cnt_b_nxt;

  logic             r_a_clean;
  logic             r_b_clean;
  logic             w_a_clean_nxt;
  logic             w_b_clean_nxt;

  logic             r_step;
  logic             r_dir;
  logic             r_err;
  logic             w_step_nxt;
  logic             w_dir_nxt;
  logic             w_err_nxt;

  logic             w_run;
  logic             w_load;
  logic             w_a_diff;
  logic             w_b_diff;
  logic             w_a_due;
  logic             w_b_due;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_s1 <= 1'b0;
      r_a_s2 <= 1'b0;
      r_b_s1 <= 1'b0;
      r_b_s2 <= 1'b0;
    end else begin
      r_a_s1 <= quadA;
      r_a_s2 <= r_a_s1;
      r_b_s1 <= quadB;
      r_b_s2 <= r_b_s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FILL;
      r_fill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  assign w_run    = (r_state == S_RUN);
  assign w_load   = (r_state == S_FILL) && r_fill;
  assign w_a_diff = r_a_s2 ^ r_a_clean;
  assign w_b_diff = r_b_s2 ^ r_b_clean;
  assign w_a_due  = w_run && w_a_diff
                 && (r_cnt_a == LP_LAST);
  assign w_b_due  = w_run && w_b_diff
                 && (r_cnt_b == LP_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    unique case (r_state)
      S_FILL: begin
        w_fill_nxt = 1'b1;
        if (r_fill) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  always_comb begin
    w_cnt_a_nxt = '0;
    w_cnt_b_nxt = '0;
    if (w_run && w_a_diff && !w_a_due) begin
      w_cnt_a_nxt = r_cnt_a + CNT_W'(1);
    end
    if (w_run && w_b_diff && !w_b_due) begin
      w_cnt_b_nxt = r_cnt_b + CNT_W'(1);
    end
  end

  always_comb begin
    w_a_clean_nxt = r_a_clean;
    w_b_clean_nxt = r_b_clean;
    w_step_nxt    = 1'b0;
    w_dir_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    unique case (1'b1)
      w_load: begin
        // s1 is what s2 takes on this edge
        w_a_clean_nxt = r_a_s1;
        w_b_clean_nxt = r_b_s1;
      end
      (w_a_due && w_b_due): begin
        w_a_clean_nxt = r_a_s2;
        w_b_clean_nxt = r_b_s2;
        w_err_nxt     = 1'b1;
      end
      (w_a_due && !w_b_due): begin
        w_a_clean_nxt = r_a_s2;
        w_step_nxt    = 1'b1;
        w_dir_nxt     = r_a_s2 ^ r_b_clean;
      end
      (w_b_due && !w_a_due): begin
        w_b_clean_nxt = r_b_s2;
        w_step_nxt    = 1'b1;
        w_dir_nxt     = ~(r_b_s2 ^ r_a_clean);
      end
      default: begin
        w_step_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_a   <= '0;
      r_cnt_b   <= '0;
      r_a_clean <= 1'b0;
      r_b_clean <= 1'b0;
      r_step    <= 1'b0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cnt_a   <= w_cnt_a_nxt;
      r_cnt_b   <= w_cnt_b_nxt;
      r_a_clean <= w_a_clean_nxt;
      r_b_clean <= w_b_clean_nxt;
      r_step    <= w_step_nxt;
      r_dir     <= w_dir_nxt;
      r_err     <= w_err_nxt;
    end
  end

`ifdef QUAD_ERR_COUNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_count = r_err_cnt;
`else
  assign err_count = 8'd0;
`endif

  assign quadA_clean = r_a_clean;
  assign quadB_clean = r_b_clean;
  assign step        = r_step;
  assign dir         = r_dir;
  assign err         = r_err;

endmodule

// File: tb/tb_quadrature_debounce.sv
// Self-checking bench for quadrature_debounce (DEBOUNCE_CYCLES=4).
// Table vectors, hand sequences and random stimulus against a model.
module tb_quadrature_debounce;

  localparam int D = 4;
`ifdef QUAD_ERR_COUNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       quadA = 1'b0;
  logic       quadB = 1'b0;
  logic       quadA_clean;
  logic       quadB_clean;
  logic       step;
  logic       dir;
  logic       err;
  logic [7:0] err_count;

  quadrature_debounce #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .quadA(quadA),
    .quadB(quadB),
    .quadA_clean(quadA_clean),
    .quadB_clean(quadB_clean),
    .step(step),
    .dir(dir),
    .err(err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_steps = 0;
  int n_fwd = 0;
  int n_errs = 0;

  // reference model state
  bit m_d1a, m_d1b, m_d2a, m_d2b;
  int m_edges;
  bit qa[$];
  bit qb[$];
  bit m_ca, m_cb, m_step, m_dir, m_err;
  int m_ecnt;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", name, got, want);
  endtask

  function automatic bit [1:0] fwd(input bit [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit held(input bit q[$], input bit c);
    if (q.size() != D) return 1'b0;
    foreach (q[i]) if (q[i] == c) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_d1a = 0; m_d1b = 0; m_d2a = 0; m_d2b = 0;
    m_edges = 0;
    qa.delete();
    qb.delete();
    m_ca = 0; m_cb = 0;
    m_step = 0; m_dir = 0; m_err = 0;
    m_ecnt = 0;
  endtask

  task automatic model_step(input bit a, input bit b);
    bit ua, ub;
    bit [1:0] old;
    m_step = 0; m_dir = 0; m_err = 0;
    if (m_edges < 2) begin
      m_edges++;
      if (m_edges == 2) begin
        m_ca = m_d1a;
        m_cb = m_d1b;
      end
    end else begin
      qa.push_back(m_d2a);
      qb.push_back(m_d2b);
      if (qa.size() > D) void'(qa.pop_front());
      if (qb.size() > D) void'(qb.pop_front());
      ua = held(qa, m_ca);
      ub = held(qb, m_cb);
      old = {m_ca, m_cb};
      if (ua && ub) begin
        m_ca = !m_ca;
        m_cb = !m_cb;
        m_err = 1;
        if (EN && m_ecnt < 255) m_ecnt++;
      end else if (ua || ub) begin
        if (ua) m_ca = !m_ca;
        else m_cb = !m_cb;
        m_step = 1;
        m_dir = ({m_ca, m_cb} == fwd(old));
      end
    end
    m_d2a = m_d1a; m_d1a = a;
    m_d2b = m_d1b; m_d1b = b;
  endtask

  task automatic cyc(input bit a, input bit b);
    bit ok;
    quadA = a;
    quadB = b;
    @(posedge clk);
    model_step(a, b);
    #1;
    if (step) n_steps++;
    if (step && dir) n_fwd++;
    if (err) n_errs++;
    ok = (quadA_clean == m_ca) && (quadB_clean == m_cb)
      && (step == m_step) && (err == m_err)
      && (!m_step || dir == m_dir)
      && (err_count == m_ecnt[7:0]);
    chk(ok, "model",
        {err_count, 3'b0, quadA_clean, quadB_clean,
         step, dir, err},
        {m_ecnt[7:0], 3'b0, m_ca, m_cb,
         m_step, m_dir, m_err});
  endtask

  task automatic do_reset(input bit a, input bit b);
    quadA = a;
    quadB = b;
    reset_n = 1'b0;
    #1;
    chk({quadA_clean, quadB_clean, step, dir, err} == 5'b0
        && err_count == 8'd0, "reset_zero",
        {err_count, quadA_clean, quadB_clean, step, dir, err},
        0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit a;
    bit b;
    bit [1:0] exp_clean;
    int exp_steps;
    int exp_fwd;
    int exp_errs;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 1, 2'b11, 1, 1, 0};
    tbl[1] = '{0, 1, 2'b01, 1, 1, 0};
    tbl[2] = '{0, 0, 2'b00, 1, 1, 0};
    tbl[3] = '{0, 1, 2'b01, 1, 0, 0};
    tbl[4] = '{1, 1, 2'b11, 1, 0, 0};
    tbl[5] = '{1, 0, 2'b10, 1, 0, 0};
    tbl[6] = '{0, 0, 2'b00, 1, 0, 0};
    tbl[7] = '{1, 1, 2'b11, 0, 0, 1};
    tbl[8] = '{0, 0, 2'b00, 0, 0, 1};
    tbl[9] = '{1, 0, 2'b10, 1, 1, 0};

    // fill with both pins high
    do_reset(1, 1);
    n_steps = 0; n_errs = 0;
    cyc(1, 1);
    chk({quadA_clean, quadB_clean} == 2'b00, "fill_edge1",
        {quadA_clean, quadB_clean}, 2'b00);
    cyc(1, 1);
    chk({quadA_clean, quadB_clean} == 2'b11, "fill_edge2",
        {quadA_clean, quadB_clean}, 2'b11);
    repeat (6) cyc(1, 1);
    chk(n_steps == 0 && n_errs == 0, "fill_quiet",
        n_steps + n_errs, 0);

    // latency from 00
    do_reset(0, 0);
    repeat (4) cyc(0, 0);
    repeat (5) cyc(1, 0);
    chk(quadA_clean == 1'b0, "lat_pre", quadA_clean, 0);
    cyc(1, 0);
    chk(quadA_clean && step && dir, "lat_edge",
        {quadA_clean, step, dir}, 3'b111);
    cyc(1, 0);
    chk(!step, "lat_one_cycle", step, 0);

    for (int i = 0; i < 10; i++) begin
      n_steps = 0; n_fwd = 0; n_errs = 0;
      repeat (7) cyc(tbl[i].a, tbl[i].b);
      chk({quadA_clean, quadB_clean} == tbl[i].exp_clean,
          $sformatf("tbl%0d_clean", i),
          {quadA_clean, quadB_clean}, tbl[i].exp_clean);
      chk(n_steps == tbl[i].exp_steps,
          $sformatf("tbl%0d_steps", i), n_steps, tbl[i].exp_steps);
      chk(n_fwd == tbl[i].exp_fwd,
          $sformatf("tbl%0d_dir", i), n_fwd, tbl[i].exp_fwd);
      chk(n_errs == tbl[i].exp_errs,
          $sformatf("tbl%0d_err", i), n_errs, tbl[i].exp_errs);
    end

    // short glitches on A
    repeat (7) cyc(0, 0);
    n_steps = 0;
    for (int i = 0; i < 10; i++) begin
      repeat (3) cyc(1, 0);
      repeat (3) cyc(0, 0);
    end
    chk(n_steps == 0 && !quadA_clean, "glitch",
        {n_steps[7:0], quadA_clean}, 0);

    // reset mid-debounce
    repeat (5) cyc(1, 0);
    do_reset(1, 0);
    n_steps = 0;
    repeat (2) cyc(1, 0);
    chk(quadA_clean && !quadB_clean, "refill",
        {quadA_clean, quadB_clean}, 2'b10);
    repeat (6) cyc(1, 0);
    chk(n_steps == 0, "no_stale_step", n_steps, 0);

    // illegal double changes and counter saturation
    do_reset(0, 0);
    repeat (2) cyc(0, 0);
    n_errs = 0;
    repeat (7) cyc(1, 1);
    chk(err_count == (EN ? 8'd1 : 8'd0), "errcnt_one",
        err_count, EN ? 1 : 0);
    repeat (7) cyc(0, 0);
    for (int i = 0; i < 149; i++) begin
      repeat (7) cyc(1, 1);
      repeat (7) cyc(0, 0);
    end
    chk(n_errs == 300, "err_pulses", n_errs, 300);
    chk(err_count == (EN ? 8'd255 : 8'd0), "errcnt_sat",
        err_count, EN ? 255 : 0);

    // random stimulus against the model
    do_reset(0, 0);
    for (int i = 0; i < 300; i++) begin
      bit ra, rb;
      int hold;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 9);
      repeat (hold) cyc(ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
